// File: rtl/vertex_unpacker.sv
// Vertex unpacker: pops DBITS-wide vertices from a show-ahead FIFO and
// emits them as NWORDS words of WBITS, least-significant word first,
// tagging the last word of each vertex and of each primitive.
//
// Output handshake: a word transfers on any cycle where out_valid and
// out_ready are both high. out_valid never drops and out_data, out_last
// and out_prim_end never change until that transfer happens.
// The only exceptions are flush and reset, which abort the vertex.
//
// busy reflects the FSM state directly: 0 = IDLE, 1 = SEND.
module vertex_unpacker #(
  parameter int DBITS      = 96,
  parameter int WBITS      = 32,
  parameter int PRIM_VERTS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [DBITS-1:0] fifo_dout,
  output logic             fifo_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WBITS-1:0] out_data,
  output logic             out_last,
  output logic             out_prim_end,
  output logic             busy,
  output logic [15:0]      vert_count
);

  localparam int NWORDS = DBITS / WBITS;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int VIDX_W = (PRIM_VERTS > 1) ? $clog2(PRIM_VERTS) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NWORDS - 1);
  localparam logic [VIDX_W-1:0] VIDX_LAST = VIDX_W'(PRIM_VERTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DBITS-1:0]   hold_q, hold_d;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic [VIDX_W-1:0]  vidx_q, vidx_d;
  logic [15:0]        vcnt_q, vcnt_d;

  logic handshake;
  logic last_word;
  logic pop;

  // Handshake / pop decode; reset gates the pop so it is 0 while reset is low.
  always_comb begin
    last_word = (widx_q == WIDX_LAST);
    handshake = (state_q == SEND) && out_ready;
    pop       = reset && enable && !fifo_empty && !flush &&
                ((state_q == IDLE) || (handshake && last_word));
  end

  // Word select from the holding register, least-significant word first.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (widx_q == WIDX_W'(i)) out_data = hold_q[i*WBITS +: WBITS];
    end
  end

  // Output decode: everything follows the registered state.
  always_comb begin
    out_valid    = (state_q == SEND);
    busy         = (state_q == SEND);
    out_last     = out_valid && last_word;
    out_prim_end = out_last && (vidx_q == VIDX_LAST);
    fifo_rd      = pop;
    vert_count   = vcnt_q;
  end

  // Next-state logic: flush wins outright; otherwise retire a word on a
  // handshake, then let a pop overwrite the holding register.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    widx_d  = widx_q;
    vidx_d  = vidx_q;
    vcnt_d  = vcnt_q;
    if (flush) begin
      state_d = IDLE;
      widx_d  = '0;
      vidx_d  = '0;
    end else begin
      if (handshake) begin
        if (last_word) begin
          vcnt_d  = vcnt_q + 16'd1;
          vidx_d  = (vidx_q == VIDX_LAST) ? '0 : vidx_q + VIDX_W'(1);
          widx_d  = '0;
          state_d = IDLE;
        end else begin
          widx_d = widx_q + WIDX_W'(1);
        end
      end
      if (pop) begin
        hold_d  = fifo_dout;
        widx_d  = '0;
        state_d = SEND;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      widx_q  <= '0;
      vidx_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      widx_q  <= widx_d;
      vidx_q  <= vidx_d;
      vcnt_q  <= vcnt_d;
    end
  end

endmodule
